cpu_ex_muldiv: RTL and testbench
================================

Name: cpu_ex_muldiv

Overview:
- Parametrised, iterative multiply/divide unit for the execute stage; extends the single-cycle ALU multiply with signed/unsigned multiply and divide.
- Results go to HI/LO registers.
- The unit holds `busy` while running; the pipeline uses it to drive `cpu_stall`.
- `int_flush` aborts an operation in flight.

Parameters:
- WIDTH, 32, operand and result width; HI/LO are each WIDTH bits.
- MUL_STEP, 1, multiplier bits retired per cycle; legal values 1, 2, 4; must divide WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  request; sampled only when not busy.
- op  in  2  operation: 00 mult (signed), 01 multu, 10 div (signed), 11 divu.
- a  in  WIDTH  multiplicand or dividend, already forwarded.
- b  in  WIDTH  multiplier or divisor, already forwarded.
- int_flush  in  1  abort the operation in flight.
- busy  out  1  an operation is in flight.
- done  out  1  one-cycle pulse when HI/LO have been updated.
- hi  out  WIDTH  multiply: upper product; divide: remainder.
- lo  out  WIDTH  multiply: lower product; divide: quotient.
- div_by_zero  out  1  sticky flag for the last operation; cleared by the next accepted start.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; busy, done, hi, lo, div_by_zero all 0. rst overrides every other input.
- States: IDLE, RUN, FIX.
  - IDLE->RUN: start=1 and int_flush=0 at an edge (E0). At E0 the unit latches op and the operand magnitudes (two's-complement absolute value for signed ops; raw values for unsigned). It also records sign_q = a[MSB]^b[MSB] and sign_r = a[MSB], and loads the iteration counter.
  - RUN: one iteration per cycle.
    - Multiply: N = WIDTH/MUL_STEP iterations of shift-add, retiring MUL_STEP bits of b per cycle into a 2*WIDTH accumulator.
    - Divide: N = WIDTH iterations of restoring shift-subtract.
    - RUN->FIX after iteration N (edge EN).
  - FIX, at edge E(N+1):
    - Signed ops: negate the product if sign_q; negate the quotient if sign_q; negate the remainder if sign_r.
    - Write hi/lo, pulse done=1 for exactly one cycle, go to IDLE.
- busy=1 from after E0 through the FIX cycle, deasserting together with done rising. done is visible N+1 cycles after the start edge (WIDTH=32: mult 33 cycles with MUL_STEP=1, 9 with MUL_STEP=4; div 33).
- Divide by zero (op[1]=1, b=0): skip RUN and go E0->FIX. At E1: lo = all ones, hi = a (original, unsigned view), div_by_zero=1, done=1.
- Signed overflow (div of -2^(WIDTH-1) by -1): lo = -2^(WIDTH-1) (0x80000000), hi=0. No flag.
- Products are exact 2*WIDTH; there is no overflow.
- start while busy: ignored. No queueing and no error.
- start in the FIX cycle: ignored, because busy=1 there. The earliest new start is accepted the cycle after done.
- int_flush:
  - With busy=1, at the next edge: go to IDLE, busy=0, done=0; hi/lo/div_by_zero keep their prior values.
  - With start=1 in the same cycle, int_flush wins and the start is dropped.
- hi/lo change only in FIX (or under reset). They are stable between operations.
- Unsigned ops ignore the sign bits entirely: multu 0xFFFFFFFF*2 gives hi=1, lo=0xFFFFFFFE.

Test Plan:
- Reset, then mult a=-3 (0xFFFFFFFD), b=7 -> busy for 33 cycles, done pulse at cycle 33, hi=0xFFFFFFFF, lo=0xFFFFFFEB; div_by_zero=0.
- multu a=0xFFFFFFFF, b=0xFFFFFFFF with MUL_STEP=4 -> done after 9 cycles, hi=0xFFFFFFFE, lo=0x00000001.
- div a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). divu a=100, b=7 -> lo=14, hi=2. Each done after 33 cycles.
- divu a=0x1234, b=0 -> done one cycle after start, lo=0xFFFFFFFF, hi=0x1234, div_by_zero=1. The next valid start clears div_by_zero.
- Start mult, assert int_flush at cycle 10 -> busy=0 next cycle, no done pulse, hi/lo equal the prior results. A start pulsed mid-operation has no effect, and only one done is produced.
- Assert rst during RUN -> next cycle busy=0, done=0, hi=lo=0, state IDLE. A new start then completes normally.

Source files
------------

// File: rtl/cpu_ex_muldiv.sv
// Iterative multiply/divide unit for the execute stage: shift-add multiply,
// restoring divide, results written to HI/LO with a one-cycle done pulse.
module cpu_ex_muldiv #(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             int_flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int PW = WIDTH + MUL_STEP;
  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic [CW-1:0]    cnt;
  logic             is_div, is_signed, sign_q, sign_r, dbz_pend;
  logic             accept, b_zero;
  logic [PW-1:0]    mul_sum;
  logic [DW-1:0]    mul_next, div_next;
  logic [WIDTH:0]   div_shift, div_diff;
  logic [WIDTH-1:0] res_hi, res_lo;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  function automatic logic [DW-1:0] neg_2w(input logic [DW-1:0] v);
    return ~v + DW'(1);
  endfunction

  function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? neg_w(v) : v;
  endfunction

  assign accept = (state == IDLE) && start && !int_flush;
  assign b_zero = (b == '0);
  assign busy   = (state != IDLE);

  // Multiply: low half of the accumulator holds the unretired multiplier bits.
  assign mul_sum  = PW'(acc_hi) + PW'(opnd) * PW'(acc_lo[MUL_STEP-1:0]);
  assign mul_next = {mul_sum, acc_lo[WIDTH-1:MUL_STEP]};

  // Divide: partial remainder in acc_hi, quotient bits shift into acc_lo.
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd};
  assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0],  acc_lo[WIDTH-2:0], 1'b1};

  always_comb begin
    res_hi = acc_hi;
    res_lo = acc_lo;
    if (!dbz_pend) begin
      if (is_div) begin
        if (is_signed && sign_q) res_lo = neg_w(acc_lo);
        if (is_signed && sign_r) res_hi = neg_w(acc_hi);
      end else if (is_signed && sign_q) begin
        {res_hi, res_lo} = neg_2w({acc_hi, acc_lo});
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (op[1] && b_zero) ? FIX : RUN;
      RUN: begin
        if (int_flush)      state_nxt = IDLE;
        else if (cnt == '0) state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == FIX) && !int_flush;
      if (accept) div_by_zero <= 1'b0;
      if ((state == FIX) && !int_flush) begin
        hi <= res_hi;
        lo <= res_lo;
        if (dbz_pend) div_by_zero <= 1'b1;
      end
    end
  end

  // Datapath registers carry no reset; they are always loaded on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      is_div    <= op[1];
      is_signed <= ~op[0];
      sign_q    <= a[WIDTH-1] ^ b[WIDTH-1];
      sign_r    <= a[WIDTH-1];
      dbz_pend  <= op[1] && b_zero;
      acc_hi    <= '0;
      if (op[1] && b_zero) begin
        acc_hi <= a;
        acc_lo <= '1;
      end else if (op[1]) begin
        acc_lo <= abs_w(a, ~op[0]);
        opnd   <= abs_w(b, ~op[0]);
        cnt    <= CW'(WIDTH - 1);
      end else begin
        acc_lo <= abs_w(b, ~op[0]);
        opnd   <= abs_w(a, ~op[0]);
        cnt    <= CW'(WIDTH / MUL_STEP - 1);
      end
    end else if (state == RUN) begin
      {acc_hi, acc_lo} <= is_div ? div_next : mul_next;
      cnt              <= cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_cpu_ex_muldiv.sv
// Directed bench for cpu_ex_muldiv: one unit with MUL_STEP=1, one with MUL_STEP=4.
module tb_cpu_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst, start, start4, int_flush;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done, dbz, busy4, done4, dbz4;
  logic [31:0] hi, lo, hi4, lo4;
  int          checks = 0;
  int          errors = 0;
  int          lat, ndone;

  always #5 clk = ~clk;

  cpu_ex_muldiv #(.WIDTH(32), .MUL_STEP(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .int_flush(int_flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(dbz)
  );

  cpu_ex_muldiv #(.WIDTH(32), .MUL_STEP(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .op(op), .a(a), .b(b), .int_flush(int_flush),
    .busy(busy4), .done(done4), .hi(hi4), .lo(lo4), .div_by_zero(dbz4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input string tag, input bit sel, input logic [1:0] o,
                     input logic [31:0] x, input logic [31:0] y, input int exp_lat,
                     input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic exp_dbz);
    int n;
    op = o; a = x; b = y;
    if (sel) start4 = 1'b1; else start = 1'b1;
    step();
    start = 1'b0; start4 = 1'b0;
    chk({tag, ".busy"}, sel ? busy4 : busy, 1);
    chk({tag, ".dbz_clr"}, sel ? dbz4 : dbz, 0);
    n = 0;
    do begin
      step();
      n++;
    end while (!(sel ? done4 : done) && n < 100);
    chk({tag, ".latency"}, n, exp_lat);
    chk({tag, ".hi"}, sel ? hi4 : hi, exp_hi);
    chk({tag, ".lo"}, sel ? lo4 : lo, exp_lo);
    chk({tag, ".dbz"}, sel ? dbz4 : dbz, exp_dbz);
    chk({tag, ".busy_off"}, sel ? busy4 : busy, 0);
    step();
    chk({tag, ".done_pulse"}, sel ? done4 : done, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start4 = 1'b0; int_flush = 1'b0;
    op = 2'b00; a = '0; b = '0;
    repeat (2) step();
    rst = 1'b0;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.hi", hi, 0);
    chk("rst.lo", lo, 0);
    chk("rst.dbz", dbz, 0);

    run("mult_m3x7", 0, 2'b00, 32'hFFFF_FFFD, 32'd7, 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
    run("multu4_max", 1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 9, 32'hFFFF_FFFE, 32'h0000_0001, 0);
    run("multu_x2", 0, 2'b01, 32'hFFFF_FFFF, 32'd2, 33, 32'h0000_0001, 32'hFFFF_FFFE, 0);
    run("div_m7d2", 0, 2'b10, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run("div_ovf", 0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0000_0000, 32'h8000_0000, 0);
    run("divu_dbz", 0, 2'b11, 32'h0000_1234, 32'd0, 1, 32'h0000_1234, 32'hFFFF_FFFF, 1);
    run("div_dbz", 0, 2'b10, 32'hFFFF_FFFB, 32'd0, 1, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1);
    run("divu_100d7", 0, 2'b11, 32'd100, 32'd7, 33, 32'd2, 32'd14, 0);

    // Flush at cycle 10 of a multiply: no done, HI/LO keep the divu result.
    op = 2'b00; a = 32'd5; b = 32'd6; start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    int_flush = 1'b1;
    step();
    int_flush = 1'b0;
    chk("flush.busy", busy, 0);
    chk("flush.done", done, 0);
    chk("flush.hi", hi, 32'd2);
    chk("flush.lo", lo, 32'd14);
    ndone = 0;
    repeat (40) begin
      step();
      if (done) ndone++;
    end
    chk("flush.no_done", ndone, 0);

    // Flush with start in the same idle cycle drops the start.
    start = 1'b1; int_flush = 1'b1;
    step();
    start = 1'b0; int_flush = 1'b0;
    chk("flush_start.busy", busy, 0);

    // Starts mid-run and in the FIX cycle are ignored.
    op = 2'b00; a = 32'd5; b = 32'd6; start = 1'b1;
    step();
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      if (lat == 5 || lat == 32) begin
        start = 1'b1; op = 2'b11; a = 32'd1; b = 32'd1;
      end else begin
        start = 1'b0;
      end
      step();
      lat++;
    end
    start = 1'b0;
    chk("busy_start.latency", lat, 33);
    chk("busy_start.hi", hi, 32'd0);
    chk("busy_start.lo", lo, 32'd30);
    step();
    chk("busy_start.busy", busy, 0);
    chk("busy_start.done", done, 0);
    ndone = 0;
    repeat (40) begin
      step();
      if (done) ndone++;
    end
    chk("busy_start.single_done", ndone, 0);

    // Reset in the middle of RUN.
    op = 2'b00; a = 32'd3; b = 32'd3; start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_run.busy", busy, 0);
    chk("rst_run.done", done, 0);
    chk("rst_run.hi", hi, 0);
    chk("rst_run.lo", lo, 0);
    chk("rst_run.dbz", dbz, 0);
    run("after_rst", 0, 2'b11, 32'd100, 32'd7, 33, 32'd2, 32'd14, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
